// File: rtl/dendrite_cfg_pkg.sv
`default_nettype none
// =====================================================================
// Package : dendrite_cfg_pkg -- shared types for the dendrite cfg loader
// Rev     : 1.0
// =====================================================================
package dendrite_cfg_pkg;
  localparam int STAGES_PER_DENDRITE = 3;
  localparam fp::fpType PAD_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/fp_pkg.sv
`default_nettype none
// =====================================================================
// Package : fp -- fixed-point word type shared by the dendrite datapath
// Rev     : 1.0
// =====================================================================
package fp;
  localparam int WORD_LENGTH = 16;
  typedef logic [WORD_LENGTH-1:0] fpType;
endpackage
`default_nettype wire

// File: rtl/dendrite_cfg_sequencer_word_buffer.sv
`default_nettype none
// =====================================================================
// Module : cfg_word_buffer -- host word store, written once, read in order
// Rev    : 1.0
// =====================================================================
module cfg_word_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             wr_en,
  input  logic [fp::WORD_LENGTH-1:0]       wr_data,
  input  logic                             rd_en,
  output logic [fp::WORD_LENGTH-1:0]       rd_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fp::fpType         r_mem [DEPTH];
  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_wr_fire;

  // Pointers are one bit wider than the index so they can sit at DEPTH without wrapping
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_wr_fire = wr_en && !w_full;

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + CW'(1);
        r_count  <= r_count + CW'(1);
      end
      if (rd_en) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  assign rd_data = r_mem[r_rd_ptr[PW-1:0]];
  assign count   = r_count;
  assign full    = w_full;
endmodule
`default_nettype wire

// File: rtl/dendrite_cfg_sequencer.sv
`default_nettype none
// =====================================================================
// Module : dendrite_cfg_sequencer -- serialises buffered E_l/tau_mem words
//          onto the dendrite cfg chain with a divided data clock
// Rev    : 1.0
// =====================================================================
module dendrite_cfg_sequencer
  import dendrite_cfg_pkg::*;
#(
  parameter int NUM_DENDRITES = 4,
  parameter int CLK_DIV       = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [fp::WORD_LENGTH-1:0] wr_data,
  input  logic                       start,
  output logic                       start_err,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_data_clk,
  output logic [fp::WORD_LENGTH-1:0] cfg_data,
  output logic                       dend_hold
);
  localparam int DEPTH = 2 * NUM_DENDRITES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW    = (NUM_DENDRITES > 1) ? $clog2(NUM_DENDRITES) : 1;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div;
  logic [1:0]      r_slot;
  logic [NW-1:0]   r_dend;
  logic [SW-1:0]   r_settle;
  logic            r_out_en;
  logic            r_start_err;
  logic            r_cfg_data_clk;
  fp::fpType       r_cfg_data;

  logic            w_div_last;
  logic            w_last_push;
  logic            w_settle_last;
  logic            w_buf_full;
  logic [CW-1:0]   w_count;
  fp::fpType       w_rd_data;
  logic            w_wr_ready;
  logic            w_wr_fire;
  logic            w_start_ok;
  logic            w_start_bad;
  logic [1:0]      w_slot_nxt;
  logic [1:0]      w_load_slot;
  logic            w_load;
  logic            w_rd_en;

  assign w_div_last    = (r_div == DW'(CLK_DIV - 1));
  assign w_last_push   = (r_slot == 2'(STAGES_PER_DENDRITE - 1)) &&
                         (r_dend == NW'(NUM_DENDRITES - 1));
  assign w_settle_last = (r_settle == SW'(SETTLE_LAST));
  assign w_slot_nxt    = (r_slot == 2'(STAGES_PER_DENDRITE - 1)) ? 2'd0 : r_slot + 2'd1;

  // r_out_en keeps wr_ready low while reset is held
  assign w_wr_ready  = r_out_en && (r_state == ST_IDLE) && !w_buf_full;
  assign w_wr_fire   = wr_valid && w_wr_ready;
  assign w_start_ok  = start && (r_state == ST_IDLE) && (w_count == CW'(DEPTH));
  assign w_start_bad = start && (r_state == ST_IDLE) && (w_count != CW'(DEPTH));

  // Slot 0 of every dendrite is the pad for its output register stage
  assign w_load_slot = (r_state == ST_IDLE) ? 2'd0 : w_slot_nxt;
  assign w_rd_en     = w_load && (w_load_slot != 2'd0);

  cfg_word_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state == ST_DONE),
    .wr_en   (w_wr_fire),
    .wr_data (wr_data),
    .rd_en   (w_rd_en),
    .rd_data (w_rd_data),
    .count   (w_count),
    .full    (w_buf_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_div_last) w_state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_div_last) begin
          if (!w_last_push) begin
            w_state_nxt = ST_SETUP;
            w_load      = 1'b1;
          end else if (SETTLE_CYCLES == 0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (w_settle_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_div          <= '0;
      r_slot         <= '0;
      r_dend         <= '0;
      r_settle       <= '0;
      r_out_en       <= 1'b0;
      r_start_err    <= 1'b0;
      r_cfg_data_clk <= 1'b0;
      r_cfg_data     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_out_en       <= 1'b1;
      r_start_err    <= w_start_bad;
      r_cfg_data_clk <= (w_state_nxt == ST_HIGH);

      if (w_load) r_cfg_data <= (w_load_slot == 2'd0) ? PAD_WORD : w_rd_data;

      if (w_state_nxt != r_state) begin
        r_div <= '0;
      end else if ((r_state == ST_SETUP) || (r_state == ST_HIGH)) begin
        r_div <= r_div + DW'(1);
      end

      if (r_state == ST_IDLE) begin
        r_slot <= '0;
        r_dend <= '0;
      end else if ((r_state == ST_HIGH) && w_div_last && !w_last_push) begin
        r_slot <= w_slot_nxt;
        if (w_slot_nxt == 2'd0) r_dend <= r_dend + NW'(1);
      end

      if (r_state == ST_SETTLE) r_settle <= r_settle + SW'(1);
      else                      r_settle <= '0;
    end
  end

  assign wr_ready     = w_wr_ready;
  assign start_err    = r_start_err;
  assign busy         = (r_state == ST_SETUP) || (r_state == ST_HIGH) || (r_state == ST_SETTLE);
  assign done         = (r_state == ST_DONE);
  assign dend_hold    = busy;
  assign cfg_data_clk = r_cfg_data_clk;
  assign cfg_data     = r_cfg_data;
endmodule
`default_nettype wire

// File: tb/tb_dendrite_cfg_sequencer.sv
`default_nettype none
// =====================================================================
// Module : tb_dendrite_cfg_sequencer -- randomized bench with chain model
// Rev    : 1.0
// =====================================================================
module tb_dendrite_cfg_sequencer;
  localparam int W  = fp::WORD_LENGTH;
  localparam int N  = 2;
  localparam int NP = 3 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: CLK_DIV=2, SETTLE=2 ; DUT B: CLK_DIV=1, SETTLE=0
  logic a_wr_valid = 0, a_wr_ready, a_start = 0, a_start_err, a_busy, a_done, a_cfg_data_clk, a_dend_hold;
  logic [W-1:0] a_wr_data = '0, a_cfg_data;
  logic b_wr_valid = 0, b_wr_ready, b_start = 0, b_start_err, b_busy, b_done, b_cfg_data_clk, b_dend_hold;
  logic [W-1:0] b_wr_data = '0, b_cfg_data;

  dendrite_cfg_sequencer #(.NUM_DENDRITES(N), .CLK_DIV(2), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst_n), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
    .start(a_start), .start_err(a_start_err), .busy(a_busy), .done(a_done),
    .cfg_data_clk(a_cfg_data_clk), .cfg_data(a_cfg_data), .dend_hold(a_dend_hold));

  dendrite_cfg_sequencer #(.NUM_DENDRITES(N), .CLK_DIV(1), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .start(b_start), .start_err(b_start_err), .busy(b_busy), .done(b_done),
    .cfg_data_clk(b_cfg_data_clk), .cfg_data(b_cfg_data), .dend_hold(b_dend_hold));

  // Monitors: record rising data_clk edges and protocol violations
  logic a_prev_clk = 0, b_prev_clk = 0;
  logic [W-1:0] a_prev_data = '0, b_prev_data = '0;
  int a_pcyc[$], b_pcyc[$];
  logic [W-1:0] a_pdat[$], b_pdat[$];
  int a_done_cnt = 0, a_done_cyc = 0, a_err_cnt = 0, a_viol = 0;
  int b_done_cnt = 0, b_done_cyc = 0, b_viol = 0;

  always @(negedge clk) begin
    if (a_cfg_data_clk && !a_prev_clk) begin a_pcyc.push_back(cyc); a_pdat.push_back(a_cfg_data); end
    if (a_cfg_data_clk && a_prev_clk && (a_cfg_data != a_prev_data)) a_viol++;
    if (a_busy && (!a_dend_hold || a_wr_ready || a_done)) a_viol++;
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
    if (a_start_err) a_err_cnt++;
    a_prev_clk = a_cfg_data_clk; a_prev_data = a_cfg_data;
    if (b_cfg_data_clk && !b_prev_clk) begin b_pcyc.push_back(cyc); b_pdat.push_back(b_cfg_data); end
    if (b_cfg_data_clk && b_prev_clk && (b_cfg_data != b_prev_data)) b_viol++;
    if (b_busy && (!b_dend_hold || b_wr_ready || b_done)) b_viol++;
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    b_prev_clk = b_cfg_data_clk; b_prev_data = b_cfg_data;
  end

  // Reference model: buffered words and the push sequence they imply
  logic [W-1:0] m_words[$];
  logic [W-1:0] exp_push[$];

  task automatic model_build();
    exp_push.delete();
    for (int d = 0; d < N; d++) begin
      exp_push.push_back('0);
      exp_push.push_back(m_words[2*d]);
      exp_push.push_back(m_words[2*d+1]);
    end
  endtask

  task automatic mon_clear();
    a_pcyc.delete(); a_pdat.delete(); b_pcyc.delete(); b_pdat.delete();
    a_done_cnt = 0; a_err_cnt = 0; a_viol = 0; b_done_cnt = 0; b_viol = 0;
  endtask

  task automatic a_write(input logic [W-1:0] d);
    a_wr_valid = 1'b1; a_wr_data = d;
    @(posedge clk); #1;
    a_wr_valid = 1'b0;
    if (m_words.size() < 2 * N) m_words.push_back(d);
  endtask

  task automatic a_pulse_start(output int s);
    a_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(output bit timeout);
    int t = 0;
    while (a_done_cnt == 0 && t < 300) begin @(posedge clk); #1; t++; end
    timeout = (a_done_cnt == 0);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_wr_ready, a_start_err, a_busy, a_done, a_cfg_data_clk, a_dend_hold} !== 6'b0 || a_cfg_data !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs %b data %h, required all 0", {a_wr_ready, a_start_err, a_busy, a_done, a_cfg_data_clk, a_dend_hold}, a_cfg_data);
    end
    n_tests++;
    if ({b_wr_ready, b_start_err, b_busy, b_done, b_cfg_data_clk, b_dend_hold} !== 6'b0) begin
      n_fail++; $display("FAIL reset_b: outputs %b, required 0", {b_wr_ready, b_start_err, b_busy, b_done, b_cfg_data_clk, b_dend_hold});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", a_wr_ready); end
  endtask

  // Full run with the fixed words plus chain contents after shifting
  task automatic test_load(input bit fixed);
    int s; bit to;
    logic [W-1:0] chain[NP];
    mon_clear(); m_words.delete();
    for (int i = 0; i < 2 * N; i++) a_write(fixed ? W'((i + 1) * 16'h1111) : W'($urandom()));
    model_build();
    a_pulse_start(s);
    a_wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL load_timeout: done never seen"); end
    n_tests++;
    if (a_pdat.size() !== NP) begin n_fail++; $display("FAIL load_push_count: got %0d required %0d", a_pdat.size(), NP); end
    for (int i = 0; i < NP && i < a_pdat.size(); i++) begin
      n_tests++;
      if (a_pdat[i] !== exp_push[i] || a_pcyc[i] - s !== 3 + 4 * i) begin
        n_fail++; $display("FAIL load_push%0d: data %h at +%0d, required %h at +%0d", i, a_pdat[i], a_pcyc[i] - s, exp_push[i], 3 + 4 * i);
      end
    end
    n_tests++;
    if (a_done_cyc - s !== 27) begin n_fail++; $display("FAIL load_latency: got %0d required 27", a_done_cyc - s); end
    for (int i = 0; i < NP; i++) chain[i] = 'x;
    foreach (a_pdat[i]) begin
      for (int k = NP - 1; k > 0; k--) chain[k] = chain[k-1];
      chain[0] = a_pdat[i];
    end
    for (int d = 0; d < N; d++) begin
      n_tests++;
      if (chain[3*d] !== m_words[2*(N-1-d)+1] || chain[3*d+1] !== m_words[2*(N-1-d)] || chain[3*d+2] !== '0) begin
        n_fail++; $display("FAIL chain_dend%0d: E_l %h tau %h out %h, required %h %h 0000", d, chain[3*d], chain[3*d+1], chain[3*d+2], m_words[2*(N-1-d)+1], m_words[2*(N-1-d)]);
      end
    end
    n_tests++;
    if (a_viol !== 0 || a_busy !== 1'b0 || a_wr_ready !== 1'b1 || a_cfg_data_clk !== 1'b0) begin
      n_fail++; $display("FAIL load_post: viol %0d busy %b ready %b dclk %b, required 0 0 1 0", a_viol, a_busy, a_wr_ready, a_cfg_data_clk);
    end
    m_words.delete();
  endtask

  task automatic test_start_err();
    int s; bit to;
    mon_clear(); m_words.delete();
    for (int i = 0; i < 3; i++) a_write(W'($urandom()));
    a_pulse_start(s);
    n_tests++;
    if (a_start_err !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL start_err_pulse: err %b busy %b, required 1 0", a_start_err, a_busy); end
    @(posedge clk); #1;
    n_tests++;
    if (a_start_err !== 1'b0 || a_busy !== 1'b0 || a_wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_err_after: err %b busy %b ready %b, required 0 0 1", a_start_err, a_busy, a_wr_ready);
    end
    a_write(W'($urandom()));
    n_tests++;
    if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL count_kept: ready %b after 4th word, required 0", a_wr_ready); end
    model_build();
    a_pulse_start(s);
    a_wait_done(to);
    n_tests++;
    if (to || a_pdat.size() !== NP || a_err_cnt !== 1) begin
      n_fail++; $display("FAIL start_err_run: timeout %b pushes %0d errs %0d, required 0 %0d 1", to, a_pdat.size(), a_err_cnt, NP);
    end
    for (int i = 0; i < NP && i < a_pdat.size(); i++) begin
      n_tests++;
      if (a_pdat[i] !== exp_push[i]) begin n_fail++; $display("FAIL start_err_push%0d: got %h required %h", i, a_pdat[i], exp_push[i]); end
    end
    m_words.delete();
  endtask

  task automatic test_full_and_midstart();
    int s, s2; bit to;
    mon_clear(); m_words.delete();
    for (int i = 0; i < 2 * N; i++) a_write(W'($urandom()));
    model_build();
    a_wr_valid = 1'b1; a_wr_data = W'($urandom());
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", a_wr_ready); end
      @(posedge clk); #1;
    end
    a_wr_valid = 1'b0;
    a_pulse_start(s);
    repeat (9) @(posedge clk);
    #1;
    a_pulse_start(s2);
    a_wait_done(to);
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (to || a_done_cnt !== 1 || a_err_cnt !== 0 || a_pdat.size() !== NP || a_viol !== 0) begin
      n_fail++; $display("FAIL midstart: timeout %b dones %0d errs %0d pushes %0d viol %0d, required 0 1 0 %0d 0", to, a_done_cnt, a_err_cnt, a_pdat.size(), NP, a_viol);
    end
    for (int i = 0; i < NP && i < a_pdat.size(); i++) begin
      n_tests++;
      if (a_pdat[i] !== exp_push[i]) begin n_fail++; $display("FAIL full_push%0d: got %h required %h", i, a_pdat[i], exp_push[i]); end
    end
    m_words.delete();
  endtask

  task automatic test_reset_midshift();
    int s, t;
    mon_clear(); m_words.delete();
    for (int i = 0; i < 2 * N; i++) a_write(W'($urandom()));
    a_pulse_start(s);
    t = 0;
    while (a_cfg_data_clk !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (a_cfg_data_clk !== 1'b1) begin n_fail++; $display("FAIL reset_reach_high: dclk %b, required 1", a_cfg_data_clk); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_cfg_data_clk, a_dend_hold, a_busy, a_done, a_wr_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_midshift: dclk/hold/busy/done/ready %b, required 00000", {a_cfg_data_clk, a_dend_hold, a_busy, a_done, a_wr_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (a_wr_ready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: ready %b busy %b, required 1 0", a_wr_ready, a_busy); end
    a_pulse_start(s);
    n_tests++;
    if (a_start_err !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_count_zero: err %b busy %b, required 1 0", a_start_err, a_busy); end
    m_words.delete();
  endtask

  task automatic test_fast();
    int s, t;
    mon_clear(); m_words.delete();
    for (int i = 0; i < 2 * N; i++) begin
      m_words.push_back(W'($urandom()));
      b_wr_valid = 1'b1; b_wr_data = m_words[i];
      @(posedge clk); #1;
    end
    b_wr_valid = 1'b0;
    model_build();
    b_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    t = 0;
    while (b_done_cnt == 0 && t < 100) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (b_done_cnt !== 1 || b_done_cyc - s !== 13) begin
      n_fail++; $display("FAIL fast_latency: dones %0d latency %0d, required 1 13", b_done_cnt, b_done_cyc - s);
    end
    n_tests++;
    if (b_pdat.size() !== NP || b_viol !== 0) begin n_fail++; $display("FAIL fast_pushes: got %0d viol %0d, required %0d 0", b_pdat.size(), b_viol, NP); end
    for (int i = 0; i < NP && i < b_pdat.size(); i++) begin
      n_tests++;
      if (b_pdat[i] !== exp_push[i] || b_pcyc[i] - s !== 2 + 2 * i) begin
        n_fail++; $display("FAIL fast_push%0d: data %h at +%0d, required %h at +%0d", i, b_pdat[i], b_pcyc[i] - s, exp_push[i], 2 + 2 * i);
      end
    end
    m_words.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_load(1'b1);
    test_load(1'b0);
    test_load(1'b0);
    test_start_err();
    test_full_and_midstart();
    test_reset_midshift();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dendrite_cfg_sequencer.md
Name: dendrite_cfg_sequencer

Overview:
Loads the per-dendrite parameters (E_l, tau_mem) into the daisy-chained dendrite configuration shift chain. The host writes two words per dendrite into an internal buffer, then issues start. The block generates a slow cfg data_clk and serialises the words onto the chain, inserting the pad word for each dendrite's output register stage. It holds the dendrites in reset while the chain is moving.

Parameters:
NUM_DENDRITES, 4, dendrites in the chain; each dendrite is 3 chain stages (E_l, tau_mem, out register).
CLK_DIV, 2, clk cycles per data_clk phase (>=1); one push = 2*CLK_DIV cycles.
SETTLE_CYCLES, 2, clk cycles of extra hold after the last push (>=0).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  host word valid
wr_ready  out  1  buffer accepts a word (idle and not full)
wr_data  in  fp::WORD_LENGTH  host word (fp::fpType)
start  in  1  single-cycle request to shift buffer into chain
start_err  out  1  one-cycle pulse: start refused (buffer count != 2*NUM_DENDRITES)
busy  out  1  shift/settle in progress
done  out  1  one-cycle pulse at end of sequence
cfg_data_clk  out  1  drives cfg_in.data_clk of first dendrite
cfg_data  out  fp::WORD_LENGTH  drives cfg_in.data_in of first dendrite
dend_hold  out  1  drives dendrite reset during configuration

Behaviour:
- Reset asserted (reset=0): all outputs 0, buffer count and pointers 0, state IDLE. Takes effect immediately, including mid-shift. The chain is left partially loaded, and the host must reload.
- Write order: host writes farthest dendrite first, per dendrite tau_mem then E_l. Total 2*NUM_DENDRITES words.
- wr_ready = (state==IDLE) && (count < 2*NUM_DENDRITES). A word is accepted on wr_valid && wr_ready. Writes while not ready are dropped.
- Start handling:
  - start in IDLE with count==2*NUM_DENDRITES: go to SETUP next cycle, busy=1, dend_hold=1.
  - start in IDLE with any other count: start_err=1 for one cycle, state unchanged.
  - start while busy is ignored, with no error.
  - start and an accepted write in the same cycle: the count check uses the pre-write count.
- Push sequence per dendrite, 3 pushes, farthest first:
  - PAD_WORD (0), then buffered tau_mem, then buffered E_l.
  - Total pushes 3*NUM_DENDRITES, so the word pushed first ends in the farthest stage.
- States:
  - IDLE: waits for start as above.
  - SETUP: cfg_data updated at entry; cfg_data_clk=0 for CLK_DIV cycles; then go to HIGH.
  - HIGH: cfg_data_clk=1 for CLK_DIV cycles, cfg_data stable. Rising edge at HIGH entry. If more pushes remain, go to SETUP; else go to SETTLE.
  - SETTLE: cfg_data_clk=0, dend_hold=1 for SETTLE_CYCLES cycles (0 means skip straight to DONE).
  - DONE: one cycle with done=1, busy=0, dend_hold=0, buffer count cleared to 0; next state IDLE.
- Data setup and hold: cfg_data changes only at SETUP entry, giving CLK_DIV cycles of setup and hold around each rising edge.
- Counters: div counter (0..CLK_DIV-1), slot counter (0..2), dendrite counter (0..NUM_DENDRITES-1), buffer read pointer.
  - Read pointer advances after each tau/E_l push and never on a pad push.
  - All counters are sized with $clog2 and wrap-free; they are reset to 0 in IDLE.
- Latency from accepted start to done: 3*NUM_DENDRITES*2*CLK_DIV + SETTLE_CYCLES + 1 cycles.
- cfg_data_clk is a registered output and never glitches. It is 0 in IDLE and DONE.

Decomposition:
- New package dendrite_cfg_pkg: state enum, PAD_WORD constant (0 of fp::fpType), STAGES_PER_DENDRITE=3.
- Word type and width come from the existing fp package.
- One sub-module, cfg_word_buffer: a write-pointer/read-pointer register file of depth 2*NUM_DENDRITES with count, full, and clear inputs.

Test Plan:
1. NUM_DENDRITES=2, CLK_DIV=2, SETTLE=2. Write 0x1111, 0x2222, 0x3333, 0x4444, then start -> cfg_data sequence at rising edges is 0x0000, 0x1111, 0x2222, 0x0000, 0x3333, 0x4444. Six rising edges, 4 cycles apart. done 27 cycles after start. Modelled chain then holds E_l1=0x2222, tau1=0x1111, E_l0=0x4444, tau0=0x3333.
2. Write 3 words, then start -> start_err pulse for 1 cycle, busy stays 0, count stays 3. Fourth write then start -> runs normally.
3. Buffer full, wr_valid held high -> wr_ready=0, fifth word not stored. During busy, wr_ready=0 throughout.
4. start pulsed again mid-shift -> ignored: no start_err, push count still 6, done only once.
5. reset driven low mid-HIGH phase -> same cycle: cfg_data_clk=0, dend_hold=0, busy=0. After release, wr_ready=1 and count=0.
6. CLK_DIV=1, SETTLE=0 -> cfg_data_clk toggles every cycle, done exactly 13 cycles after start.
